// File: rtl/decimal_input_unit_pkg.sv
// Shared types and constants for the decimal entry front end.
package decimal_input_unit_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [9:0] MAX_POS_MAG = 10'd127;
  localparam logic [9:0] MAX_NEG_MAG = 10'd128;
  localparam logic [1:0] MAX_DIGITS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_CONVERT = 2'd2
  } state_t;

  // Binary magnitude of a three-digit BCD entry {hundreds, tens, ones}.
  // The largest result is 999, so 10 bits always hold it.
  function automatic logic [9:0] bcd_to_mag(input logic [3*BCD_W-1:0] bcd);
    bcd_to_mag = 10'(bcd[11:8]) * 10'd100
               + 10'(bcd[7:4])  * 10'd10
               + 10'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/decimal_input_unit_if.sv
// Key inputs and entry/result outputs of the decimal entry unit.
// Signalling: there is no backpressure. value_valid is a one-cycle
// qualifier that marks the cycle in which value_out took a new value;
// value_out holds that value until the next successful commit or reset.
interface decimal_input_unit_if;
  import decimal_input_unit_pkg::*;

  logic [BCD_W-1:0]   digit_in;
  logic               digit_key;
  logic               sign_key;
  logic               enter_key;
  logic               clear_key;
  logic [7:0]         value_out;
  logic               value_valid;
  logic               overflow_err;
  logic               entry_sign;
  logic [3*BCD_W-1:0] entry_bcd;
  logic [1:0]         digit_count;
  state_t             fsm_state;

  modport master (
    output digit_in, digit_key, sign_key, enter_key, clear_key,
    input  value_out, value_valid, overflow_err, entry_sign, entry_bcd,
           digit_count, fsm_state
  );

  modport slave (
    input  digit_in, digit_key, sign_key, enter_key, clear_key,
    output value_out, value_valid, overflow_err, entry_sign, entry_bcd,
           digit_count, fsm_state
  );

endinterface

// File: rtl/decimal_input_unit_key_conditioner.sv
// One raw button -> one-cycle pulse per press.
// Two-flop synchronizer, optional debounce (KEY_DEBOUNCE_EN), then a
// registered rising-edge detector. A held key produces a single pulse.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic level;
  logic level_prev_q;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // Accept a new level only after it has differed from the current one
  // for DEBOUNCE_CYCLES consecutive cycles; any return restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  // Registered rising-edge detect on the conditioned level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
      key_pulse    <= 1'b0;
    end else begin
      level_prev_q <= level;
      key_pulse    <= level & ~level_prev_q;
    end
  end

endmodule

// File: rtl/decimal_input_unit.sv
// Decimal entry front end: up to three BCD digits plus a sign are keyed
// in, then converted to an 8-bit two's-complement value with range check.
// Optional build macro: KEY_DEBOUNCE_EN (adds per-key debounce).
module decimal_input_unit
  import decimal_input_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input logic                 clk,
  input logic                 rst_n,
  decimal_input_unit_if.slave bus
);

  logic dig_p, sgn_p, ent_p, clr_p;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kc_digit (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.digit_key), .key_pulse(dig_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kc_sign (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.sign_key), .key_pulse(sgn_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kc_enter (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.enter_key), .key_pulse(ent_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kc_clear (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.clear_key), .key_pulse(clr_p));

  state_t             state_q, state_d;
  logic [3*BCD_W-1:0] bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic [1:0]         count_q, count_d;
  logic [7:0]         value_q, value_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic       digit_ok;
  logic [9:0] mag;
  logic       in_range;

  assign digit_ok = (bus.digit_in <= 4'd9) && (count_q < MAX_DIGITS);
  assign mag      = bcd_to_mag(bcd_q);
  assign in_range = sign_q ? (mag <= MAX_NEG_MAG) : (mag <= MAX_POS_MAG);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state and datapath updates. Only the highest-priority key pulse
  // in a cycle acts (clear > enter > sign > digit); CONVERT ignores keys.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (clr_p) begin
          bcd_d   = '0;
          sign_d  = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (ent_p) begin
          state_d = ST_CONVERT;
        end else if (sgn_p) begin
          sign_d  = ~sign_q;
          state_d = ST_ENTRY;
        end else if (dig_p && digit_ok) begin
          bcd_d   = {bcd_q[2*BCD_W-1:0], bus.digit_in};
          count_d = count_q + 2'd1;
          ovf_d   = 1'b0;
          state_d = ST_ENTRY;
        end
      end
      ST_CONVERT: begin
        if (in_range) begin
          // "-0" negates to 0x00, and -128 wraps onto itself, both correct.
          value_d = sign_q ? (~mag[7:0] + 8'd1) : mag[7:0];
          valid_d = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          ovf_d   = 1'b1;
        end
        bcd_d   = '0;
        sign_d  = 1'b0;
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.value_out    = value_q;
  assign bus.value_valid  = valid_q;
  assign bus.overflow_err = ovf_q;
  assign bus.entry_sign   = sign_q;
  assign bus.entry_bcd    = bcd_q;
  assign bus.digit_count  = count_q;
  assign bus.fsm_state    = state_q;

endmodule
